// File: rtl/matmul_pkg.sv
// Shared state/stage encodings and packing helpers for the matmul sequencer.
// Used by matmul_ctrl and matmul_idx_cnt.
package matmul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL_REQ,
    ST_MUL_WAIT,
    ST_ADD_REQ,
    ST_ADD_WAIT,
    ST_STORE,
    ST_DONE
  } state_e;

  // Stage codes common to matmul and matmul_ctrl
  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_MUL  = 2'd1,
    S_ADD  = 2'd2
  } stage_e;

  function automatic stage_e stage_of(state_e st);
    case (st)
      ST_MUL_REQ, ST_MUL_WAIT: return S_MUL;
      ST_ADD_REQ, ST_ADD_WAIT: return S_ADD;
      default:                 return S_INIT;
    endcase
  endfunction

  // LSB of element (r,c) in a row-major rows x cols matrix, element (0,0) in the MSBs
  function automatic int unsigned elem_lsb(int unsigned s, int unsigned rows,
                                           int unsigned cols, int unsigned r,
                                           int unsigned c);
    return s * (rows * cols - (r * cols + c) - 1);
  endfunction

  function automatic int unsigned idx_w(int unsigned h, int unsigned w, int unsigned c);
    int unsigned m;
    m = 2;
    if (h > m) m = h;
    if (w > m) m = w;
    if (c > m) m = c;
    return unsigned'($clog2(m));
  endfunction

endpackage

// File: rtl/matmul_idx_cnt.sv
// Nested i/j/k index walker for the matmul sequencer: k steps within a dot
// product, step_ij clears k and advances j, wrapping into i.
module matmul_idx_cnt
  import matmul_pkg::*;
#(
  parameter int unsigned H  = 2,
  parameter int unsigned W  = 2,
  parameter int unsigned C  = 2,
  parameter int unsigned IW = idx_w(H, W, C)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          step_k_i,
  input  logic          step_ij_i,
  output logic [IW-1:0] i_o,
  output logic [IW-1:0] j_o,
  output logic [IW-1:0] k_o,
  output logic          last_k_o,
  output logic          last_ij_o
);

  logic [IW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end

  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    if (clear_i) begin
      i_d = '0;
      j_d = '0;
      k_d = '0;
    end else if (step_ij_i) begin
      k_d = '0;
      if (j_q == IW'(W - 1)) begin
        j_d = '0;
        i_d = (i_q == IW'(H - 1)) ? '0 : i_q + IW'(1);
      end else begin
        j_d = j_q + IW'(1);
      end
    end else if (step_k_i) begin
      k_d = k_q + IW'(1);
    end
  end

  assign i_o       = i_q;
  assign j_o       = j_q;
  assign k_o       = k_q;
  assign last_k_o  = (k_q == IW'(C - 1));
  assign last_ij_o = (i_q == IW'(H - 1)) && (j_q == IW'(W - 1));

endmodule

// File: rtl/matmul_ctrl.sv
// Sequences an H x W float matrix product through one shared multiplier and adder.
// Optional sticky exception flags: define MATMUL_CTRL_STATUS_EN.
module matmul_ctrl
  import matmul_pkg::*;
#(
  parameter int unsigned S = 32,
  parameter int unsigned H = 2,
  parameter int unsigned W = 2,
  parameter int unsigned C = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [S*H*C-1:0] a,
  input  logic [S*C*W-1:0] b,
  output logic [S*H*W-1:0] o,
  output logic             busy,
  output logic             done,
  output logic             mul_start,
  output logic             add_start,
  output logic [S-1:0]     mul_op1,
  output logic [S-1:0]     mul_op2,
  output logic [S-1:0]     add_op1,
  output logic [S-1:0]     add_op2,
  input  logic [S-1:0]     mul_out,
  input  logic [S-1:0]     add_out,
  input  logic             mul_done,
  input  logic             add_done
`ifdef MATMUL_CTRL_STATUS_EN
  ,
  input  logic [3:0]       mul_exc,
  input  logic [3:0]       add_exc,
  output logic [3:0]       status
`endif
);

  localparam int unsigned IW = idx_w(H, W, C);

  state_e             state_q, state_d;
  stage_e             stage;
  logic [S*H*C-1:0]   a_q, a_d;
  logic [S*C*W-1:0]   b_q, b_d;
  logic [S*H*W-1:0]   o_q, o_d;
  logic [S-1:0]       acc_q, acc_d, prod_q, prod_d;
  logic               cnt_clear, step_k, step_ij, last_k, last_ij;
  logic [IW-1:0]      i_idx, j_idx, k_idx;

  matmul_idx_cnt #(.H(H), .W(W), .C(C), .IW(IW)) u_idx (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (cnt_clear),
    .step_k_i (step_k),
    .step_ij_i(step_ij),
    .i_o      (i_idx),
    .j_o      (j_idx),
    .k_o      (k_idx),
    .last_k_o (last_k),
    .last_ij_o(last_ij)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      o_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      o_q     <= o_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    o_d       = o_q;
    acc_d     = acc_q;
    prod_d    = prod_q;
    cnt_clear = 1'b0;
    step_k    = 1'b0;
    step_ij   = 1'b0;
    mul_start = 1'b0;
    add_start = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d       = a;
          b_d       = b;
          acc_d     = '0;
          cnt_clear = 1'b1;
          state_d   = ST_MUL_REQ;
        end
      end
      ST_MUL_REQ: begin
        mul_start = 1'b1;
        state_d   = ST_MUL_WAIT;
      end
      ST_MUL_WAIT: begin
        if (mul_done) begin
          prod_d = mul_out;
          // First term seeds the accumulator directly; no add needed
          if (k_idx == '0) begin
            acc_d = mul_out;
            if (last_k) begin
              state_d = ST_STORE;
            end else begin
              step_k  = 1'b1;
              state_d = ST_MUL_REQ;
            end
          end else begin
            state_d = ST_ADD_REQ;
          end
        end
      end
      ST_ADD_REQ: begin
        add_start = 1'b1;
        state_d   = ST_ADD_WAIT;
      end
      ST_ADD_WAIT: begin
        if (add_done) begin
          acc_d = add_out;
          if (last_k) begin
            state_d = ST_STORE;
          end else begin
            step_k  = 1'b1;
            state_d = ST_MUL_REQ;
          end
        end
      end
      ST_STORE: begin
        o_d[elem_lsb(S, H, W, 32'(i_idx), 32'(j_idx)) +: S] = acc_q;
        step_ij = 1'b1;
        state_d = last_ij ? ST_DONE : ST_MUL_REQ;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operands derive from registered state only, so they stay put from REQ through WAIT
  assign stage   = stage_of(state_q);
  assign mul_op1 = (stage == S_MUL) ? a_q[elem_lsb(S, H, C, 32'(i_idx), 32'(k_idx)) +: S] : '0;
  assign mul_op2 = (stage == S_MUL) ? b_q[elem_lsb(S, C, W, 32'(k_idx), 32'(j_idx)) +: S] : '0;
  assign add_op1 = (stage == S_ADD) ? acc_q  : '0;
  assign add_op2 = (stage == S_ADD) ? prod_q : '0;
  assign busy    = (state_q != ST_IDLE);
  assign o       = o_q;

`ifdef MATMUL_CTRL_STATUS_EN
  logic [3:0] status_q, status_d;

  always_comb begin
    status_d = status_q;
    if (state_q == ST_IDLE && start) begin
      status_d = '0;
    end else if (state_q == ST_MUL_WAIT && mul_done) begin
      status_d = status_q | mul_exc;
    end else if (state_q == ST_ADD_WAIT && add_done) begin
      status_d = status_q | add_exc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) status_q <= '0;
    else        status_q <= status_d;
  end

  assign status = status_q;
`endif

endmodule

// File: tb/tb_matmul_ctrl.sv
// Bench for matmul_ctrl: two instances (2x2x2 and 2x2x1) with latency-programmable
// stub float units, checked against an integer matrix-product reference.
module tb_matmul_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   start_v, busy_v, done_v, mst, ast, mdone, adone, aspur;
  logic [127:0] a0, b0, o0, o1;
  logic [63:0]  a1, b1;
  logic [31:0]  mop1[2], mop2[2], aop1[2], aop2[2];
  logic [31:0]  mres[2], ares[2], mexp1[2], mexp2[2], aexp1[2], aexp2[2];
  int           mcnt[2], acnt[2];
  int           lm, la;
  int           stab_bad = 0;
  int           add1_cnt = 0;
  int           n_chk = 0;
  int           n_bad = 0;
  int           av[4], bv[4];
  int           dcyc;

`ifdef MATMUL_CTRL_STATUS_EN
  logic [3:0]   mexc[2], aexc[2], st_v[2];
  logic [1:0]   exc_inj;
  assign mexc[0] = (mcnt[0] == 1 && exc_inj[0]) ? 4'b0100 : 4'b0000;
  assign mexc[1] = (mcnt[1] == 1 && exc_inj[1]) ? 4'b0100 : 4'b0000;
  assign aexc[0] = 4'b0000;
  assign aexc[1] = 4'b0000;
`endif

  always #5 clk = ~clk;

  matmul_ctrl #(.S(32), .H(2), .W(2), .C(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a0), .b(b0), .o(o0),
    .busy(busy_v[0]), .done(done_v[0]), .mul_start(mst[0]), .add_start(ast[0]),
    .mul_op1(mop1[0]), .mul_op2(mop2[0]), .add_op1(aop1[0]), .add_op2(aop2[0]),
    .mul_out(mres[0]), .add_out(ares[0]), .mul_done(mdone[0]), .add_done(adone[0])
`ifdef MATMUL_CTRL_STATUS_EN
    , .mul_exc(mexc[0]), .add_exc(aexc[0]), .status(st_v[0])
`endif
  );

  matmul_ctrl #(.S(32), .H(2), .W(2), .C(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a1), .b(b1), .o(o1),
    .busy(busy_v[1]), .done(done_v[1]), .mul_start(mst[1]), .add_start(ast[1]),
    .mul_op1(mop1[1]), .mul_op2(mop2[1]), .add_op1(aop1[1]), .add_op2(aop2[1]),
    .mul_out(mres[1]), .add_out(ares[1]), .mul_done(mdone[1]), .add_done(adone[1])
`ifdef MATMUL_CTRL_STATUS_EN
    , .mul_exc(mexc[1]), .add_exc(aexc[1]), .status(st_v[1])
`endif
  );

  // Small non-negative integers as IEEE single; exact for values below 2^24
  function automatic logic [31:0] i2f(int unsigned n);
    int p;
    logic [31:0] m;
    if (n == 0) return 32'h0;
    p = 31;
    while (p > 0 && !n[p]) p--;
    m = n << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  function automatic int unsigned f2i(logic [31:0] f);
    int e;
    logic [31:0] m;
    if (f[30:0] == 31'h0) return 0;
    e = int'(f[30:23]) - 127;
    m = {8'h0, 1'b1, f[22:0]};
    return m >> (23 - e);
  endfunction

  function automatic logic [127:0] pack(int v[4], int n);
    logic [127:0] r;
    r = '0;
    for (int e = 0; e < n; e++) r[32*(n-1-e) +: 32] = i2f(v[e]);
    return r;
  endfunction

  function automatic logic [127:0] ref_o(int cdim);
    int vals[4];
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        vals[r*2+c] = 0;
        for (int k = 0; k < cdim; k++) vals[r*2+c] += av[r*cdim+k] * bv[k*2+c];
      end
    return pack(vals, 4);
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  assign mdone[0] = (mcnt[0] == 1);
  assign mdone[1] = (mcnt[1] == 1);
  assign adone[0] = (acnt[0] == 1) | aspur[0];
  assign adone[1] = (acnt[1] == 1) | aspur[1];

  // Stub units: result ready lm/la cycles after the start cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        mcnt[d] <= 0;
        acnt[d] <= 0;
        mres[d] <= '0;
        ares[d] <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (mst[d]) begin
          mcnt[d]  <= lm;
          mres[d]  <= i2f(f2i(mop1[d]) * f2i(mop2[d]));
          mexp1[d] <= mop1[d];
          mexp2[d] <= mop2[d];
        end else if (mcnt[d] != 0) begin
          mcnt[d] <= mcnt[d] - 1;
        end
        if (ast[d]) begin
          acnt[d]  <= la;
          ares[d]  <= i2f(f2i(aop1[d]) + f2i(aop2[d]));
          aexp1[d] <= aop1[d];
          aexp2[d] <= aop2[d];
        end else if (acnt[d] != 0) begin
          acnt[d] <= acnt[d] - 1;
        end
      end
      if (ast[1]) add1_cnt <= add1_cnt + 1;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mcnt[d] != 0 && (mop1[d] !== mexp1[d] || mop2[d] !== mexp2[d])) stab_bad <= stab_bad + 1;
      if (acnt[d] != 0 && (aop1[d] !== aexp1[d] || aop2[d] !== aexp2[d])) stab_bad <= stab_bad + 1;
    end
  end

  // mode bit0: re-pulse start, alter inputs and inject a spurious add_done mid-run
  // mode bit1: flag an exception on the first multiply
  task automatic run(input int d, input int cdim, input int mode, input int rst_at,
                     output int done_at);
    logic [127:0] exp_o, oo;
    logic [3:0]   exp_st;
    int n, pe, sb0;
    bit got, spur_done, exc_seen;
    exp_o  = ref_o(cdim);
    exp_st = mode[1] ? 4'b0100 : 4'b0000;
    pe     = cdim * (lm + 1) + (cdim - 1) * (la + 1) + 1;
    done_at = -1;
    @(negedge clk);
    if (d == 0) begin
      a0 = pack(av, 4);
      b0 = pack(bv, 4);
    end else begin
      a1 = 64'(pack(av, 2));
      b1 = 64'(pack(bv, 2));
    end
`ifdef MATMUL_CTRL_STATUS_EN
    exc_inj[d] = mode[1];
`endif
    sb0 = stab_bad;
    start_v[d] = 1'b1;
    @(posedge clk);
    #1 start_v[d] = 1'b0;
    n = 1;
    got = 0;
    spur_done = 0;
    exc_seen = 0;
    while (n < 400) begin
      @(negedge clk);
      aspur[d] = 1'b0;
      if (n == 1) chk("busy_up", busy_v[d], 1);
`ifdef MATMUL_CTRL_STATUS_EN
      if (n == 1) chk("status_clr", st_v[d], 0);
      if (mdone[d]) exc_seen = 1;
      else if (exc_seen) exc_inj[d] = 1'b0;
`endif
      if (done_v[d]) begin
        got = 1;
        break;
      end
      if (mode[0]) begin
        if (n == 4) begin
          start_v[d] = 1'b1;
          if (d == 0) a0 = ~a0; else a1 = ~a1;
        end
        if (n == 5) start_v[d] = 1'b0;
        if (n >= 8 && mcnt[d] != 0 && !spur_done) begin
          aspur[d] = 1'b1;
          spur_done = 1;
        end
      end
      if (rst_at != 0 && n == rst_at) begin
        rst_n = 1'b0;
        #1;
        oo = (d == 0) ? o0 : o1;
        chk("rst_o", oo, 0);
        chk("rst_busy", busy_v[d], 0);
        chk("rst_done", done_v[d], 0);
        chk("rst_mstart", mst[d], 0);
        chk("rst_mop1", mop1[d], 0);
        chk("rst_aop1", aop1[d], 0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      @(posedge clk);
      n++;
    end
    aspur[d] = 1'b0;
    chk("done_seen", got, 1);
    if (got) begin
      done_at = n;
      oo = (d == 0) ? o0 : o1;
      chk("result", oo, exp_o);
      chk("done_cycle", n, 1 + 4 * pe);
      chk("op_stable", stab_bad - sb0, 0);
`ifdef MATMUL_CTRL_STATUS_EN
      chk("status", st_v[d], exp_st);
      exc_inj[d] = 1'b0;
`endif
      @(negedge clk);
      oo = (d == 0) ? o0 : o1;
      chk("done_pulse", done_v[d], 0);
      chk("busy_low", busy_v[d], 0);
      chk("o_hold", oo, exp_o);
    end
  endtask

  initial begin
    int s0;
    rst_n   = 1'b0;
    start_v = '0;
    aspur   = '0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    lm = 1;
    la = 1;
`ifdef MATMUL_CTRL_STATUS_EN
    exc_inj = '0;
`endif
    repeat (2) @(negedge clk);
    chk("reset_o", o0, 0);
    chk("reset_busy", busy_v, 0);
    chk("reset_done", done_v, 0);
    chk("reset_starts", {mst, ast}, 0);
    chk("reset_ops", {mop1[0], mop2[0], aop1[0], aop2[0]}, 0);
`ifdef MATMUL_CTRL_STATUS_EN
    chk("reset_status", st_v[0], 0);
`endif
    rst_n = 1'b1;

    av = '{1, 2, 3, 4};
    bv = '{5, 6, 7, 8};
    run(0, 2, 0, 0, dcyc);
    chk("known_o", o0, 128'h41980000_41B00000_422C0000_42480000);
    chk("known_cycle", dcyc, 29);

    av = '{2, 3, 0, 0};
    bv = '{2, 4, 0, 0};
    s0 = add1_cnt;
    run(1, 1, 0, 0, dcyc);
    chk("c1_o", o1, 128'h40800000_41000000_40C00000_41400000);
    chk("c1_no_add", add1_cnt - s0, 0);

    lm = 5;
    la = 3;
    av = '{1, 2, 3, 4};
    bv = '{5, 6, 7, 8};
    run(0, 2, 0, 0, dcyc);
    chk("slow_cycle", dcyc, 69);

    lm = 2;
    la = 2;
    run(0, 2, 1, 0, dcyc);

    lm = 1;
    la = 1;
    av = '{3, 1, 4, 1};
    bv = '{5, 9, 2, 6};
    run(0, 2, 0, 17, dcyc);
    run(0, 2, 0, 0, dcyc);

`ifdef MATMUL_CTRL_STATUS_EN
    run(0, 2, 2, 0, dcyc);
    run(0, 2, 0, 0, dcyc);
`endif

    for (int it = 0; it < 8; it++) begin
      int d;
      lm = $urandom_range(1, 4);
      la = $urandom_range(1, 4);
      for (int e = 0; e < 4; e++) begin
        av[e] = $urandom_range(0, 15);
        bv[e] = $urandom_range(0, 15);
      end
      d = $urandom_range(0, 1);
      s0 = add1_cnt;
      run(d, (d == 0) ? 2 : 1, (it % 3 == 0) ? 1 : 0, 0, dcyc);
      if (d == 1) chk("rand_c1_no_add", add1_cnt - s0, 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
